nibble_serial_adder_16_bit: RTL and testbench

Multi-cycle 16-bit adder that sequences operands one 4-bit slice per clock through a single instance of the team's 4-bit carry lookahead slice (carry_lookahead_adder_4_bit). A registered carry chains the slices together. The block sits directly upstream of that slice and feeds its A/B/Cin. It then consumes the slice's Sum/Cout and assembles the full-width result. It is the low-area alternative to the parallel 16-bit CLA tree, with a Start/Done handshake toward the datapath controller.

---
 rtl/nibble_serial_adder_16_bit.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder_16_bit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_16_bit.sv
// Nibble-serial adder: one 4-bit CLA slice reused across WIDTH/4 clocks,
// chained through a registered carry, with a Start/Busy/Done handshake.

module carry_lookahead_adder_4_bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

module nibble_serial_adder_16_bit #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [N-1:0][3:0] a_q;
    logic [N-1:0][3:0] b_q;
    logic [N-1:0][3:0] psum;
    logic [N-1:0][3:0] psum_nxt;
    logic              carry;
    logic [CW-1:0]     step;
    logic [3:0]        s_sum;
    logic              s_cout;

    carry_lookahead_adder_4_bit u_slice (
        .A    (a_q[step]),
        .B    (b_q[step]),
        .Cin  (carry),
        .Sum  (s_sum),
        .Cout (s_cout)
    );

    // Final nibble goes straight from the slice into Sum on the last edge.
    always_comb begin
        psum_nxt       = psum;
        psum_nxt[step] = s_sum;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            psum     <= '0;
            carry    <= 1'b0;
            step     <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= Cin;
                        step  <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    psum  <= psum_nxt;
                    carry <= s_cout;
                    step  <= step + CW'(1);
                    if (step == LAST) begin
                        Sum      <= psum_nxt;
                        Cout     <= s_cout;
                        Overflow <= a_q[N-1][3] ^ b_q[N-1][3]
                                  ^ s_sum[3] ^ s_cout;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_16_bit.sv
// Scoreboard bench for nibble_serial_adder_16_bit: driver pushes
// arithmetic-model expectations, a negedge monitor pops them on Done.

module tb_nibble_serial_adder_16_bit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] Sum;
    logic        Cout;
    logic        Overflow;
    logic        Busy;
    logic        Done;

    nibble_serial_adder_16_bit #(.WIDTH(16)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] held     = '0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                   logic c, int t);
        exp_t e;
        int   u;
        int   s;
        u   = int'(a) + int'(b) + int'(c);
        s   = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.s = u[15:0];
        e.c = (u > 65535);
        e.v = (s > 32767) || (s < -32768);
        e.t = t;
        return e;
    endfunction

    // Monitor: checks every Done against the scoreboard and that Sum holds otherwise.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            held = '0;
        end else begin
            check("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
            if (Done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got Done=1 required no pending op");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", {16'd0, Sum}, {16'd0, e.s});
                    check("cout", {31'd0, Cout}, {31'd0, e.c});
                    check("overflow", {31'd0, Overflow}, {31'd0, e.v});
                    check("done_latency", cyc, e.t);
                    held = e.s;
                end
            end else begin
                check("sum_hold", {16'd0, Sum}, {16'd0, held});
            end
        end
    end

    task automatic start_op(logic [15:0] a, logic [15:0] b, logic c);
        A     = a;
        B     = b;
        Cin   = c;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        sb.push_back(model(a, b, c, cyc + 4));
        Start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done) return;
            if (Busy) nbusy++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no Done required Done within 20 cycles");
    endtask

    logic [15:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] tb[4] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000};
    logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] ts[4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
    logic        tco[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        tov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int nb;
        Reset_n = 1'b0;
        Start   = 1'b0;
        A       = '0;
        B       = '0;
        Cin     = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_sum", {16'd0, Sum}, 32'd0);
        check("rst_flags", {27'd0, Cout, Overflow, Busy, Done, 1'b0}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(nb);
        check("busy_cycles", nb, 4);
        check("basic_sum", {16'd0, Sum}, 32'h5555);
        repeat (3) @(negedge Clk);
        check("sum_idle", {16'd0, Sum}, 32'h5555);

        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            wait_done(nb);
            check("edge_sum", {16'd0, Sum}, {16'd0, ts[i]});
            check("edge_flags", {30'd0, Cout, Overflow}, {30'd0, tco[i], tov[i]});
            @(negedge Clk);
        end

        // Start held high and operands scrambled while running.
        A     = 16'h1111;
        B     = 16'h2222;
        Cin   = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        sb.push_back(model(16'h1111, 16'h2222, 1'b0, cyc + 4));
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Done) break;
            A = 16'($urandom);
            B = 16'($urandom);
        end
        Start = 1'b0;
        check("held_start_sum", {16'd0, Sum}, 32'h3333);
        @(negedge Clk);
        check("held_start_idle", {31'd0, Busy}, 32'd0);

        start_op(16'h0001, 16'h0002, 1'b0);
        wait_done(nb);
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        @(negedge Clk);
        check("b2b_busy", {31'd0, Busy}, 32'd1);
        wait_done(nb);
        check("b2b_sum", {16'd0, Sum}, 32'h1000);
        check("b2b_cout", {31'd0, Cout}, 32'd0);
        @(negedge Clk);

        start_op(16'h1357, 16'h2468, 1'b1);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_sum", {16'd0, Sum}, 32'd0);
        check("async_rst_flags", {28'd0, Cout, Overflow, Busy, Done}, 32'd0);
        sb.delete();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done(nb);
        check("post_rst_sum", {16'd0, Sum}, 32'h0002);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            if ($urandom_range(0, 1) == 0) @(negedge Clk);
            start_op(ra, rb, 1'($urandom));
            wait_done(nb);
            check("rand_busy_cycles", nb, 4);
        end

        repeat (3) @(negedge Clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
